// File: rtl/reservation_station_pkg.sv
// Shared widths, entry layout and the CDB snoop helper for the reservation station.
// An operand is "present" once its tag is ZERO_ROB; until then the value field is don't-care.
package reservation_station_pkg;

  localparam int RS_DEPTH      = 16;
  localparam int RS_WIDTH      = 4;
  localparam logic [RS_WIDTH-1:0] ZERO_RS = '0;

  localparam int OPERATION_BUS = 6;
  localparam int ROB_WIDTH     = 4;
  localparam int DATA_WIDTH    = 32;
  localparam logic [ROB_WIDTH-1:0]     ZERO_ROB = '0;
  localparam logic [OPERATION_BUS-1:0] NOP      = '0;

  typedef struct packed {
    logic [ROB_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] value;
  } operand_t;

  typedef struct packed {
    logic [OPERATION_BUS-1:0] op;
    logic [DATA_WIDTH-1:0]    imm;
    logic [DATA_WIDTH-1:0]    pc;
    logic [ROB_WIDTH-1:0]     dest;
    operand_t                 src1;
    operand_t                 src2;
  } rs_entry_t;

  // A pending operand grabs whichever CDB carries its tag; tag 0 can never match.
  function automatic operand_t snoopOperand(
    input operand_t              cur,
    input logic                  aluValid,
    input logic [ROB_WIDTH-1:0]  aluTag,
    input logic [DATA_WIDTH-1:0] aluValue,
    input logic                  lsbValid,
    input logic [ROB_WIDTH-1:0]  lsbTag,
    input logic [DATA_WIDTH-1:0] lsbValue
  );
    operand_t res;
    res = cur;
    if (cur.tag != ZERO_ROB) begin
      if (aluValid && (aluTag == cur.tag)) begin
        res.tag   = ZERO_ROB;
        res.value = aluValue;
      end else if (lsbValid && (lsbTag == cur.tag)) begin
        res.tag   = ZERO_ROB;
        res.value = lsbValue;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/reservation_station_select.sv
// Lowest-index priority encoder: reports the first set bit of reqVec_i and whether any bit was set.
module rs_select
  import reservation_station_pkg::*;
#(
  parameter int N = RS_DEPTH,
  parameter int W = RS_WIDTH
) (
  input  logic [N-1:0] reqVec_i,
  output logic [W-1:0] idx_o,
  output logic         found_o
);

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    idx_o   = W'(ZERO_RS);
    found_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (reqVec_i[i]) begin
        idx_o   = W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Reservation station between decode and the ALU: holds dispatched ops, snoops both CDBs for
// missing operands and issues the lowest-index ready entry each cycle.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int RS_SIZE  = RS_DEPTH,
  parameter int RS_IDX_W = RS_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [OPERATION_BUS-1:0] in_op,
  input  logic [DATA_WIDTH-1:0]    in_imm,
  input  logic [DATA_WIDTH-1:0]    in_pc,
  input  logic [DATA_WIDTH-1:0]    in_operand1,
  input  logic [DATA_WIDTH-1:0]    in_operand2,
  input  logic [ROB_WIDTH-1:0]     in_tag1,
  input  logic [ROB_WIDTH-1:0]     in_tag2,
  input  logic [ROB_WIDTH-1:0]     in_dest,
  output logic                     full,
  input  logic                     alu_cdb_valid,
  input  logic [ROB_WIDTH-1:0]     alu_cdb_tag,
  input  logic [DATA_WIDTH-1:0]    alu_cdb_value,
  input  logic                     lsb_cdb_valid,
  input  logic [ROB_WIDTH-1:0]     lsb_cdb_tag,
  input  logic [DATA_WIDTH-1:0]    lsb_cdb_value,
  output logic                     out_valid,
  output logic [OPERATION_BUS-1:0] out_op,
  output logic [DATA_WIDTH-1:0]    out_operand1,
  output logic [DATA_WIDTH-1:0]    out_operand2,
  output logic [DATA_WIDTH-1:0]    out_imm,
  output logic [DATA_WIDTH-1:0]    out_pc,
  output logic [ROB_WIDTH-1:0]     out_dest
);

  rs_entry_t           ent_q [RS_SIZE];
  rs_entry_t           ent_d [RS_SIZE];
  logic [RS_SIZE-1:0]  busy_q, busy_d;
  logic [RS_SIZE-1:0]  readyVec;
  logic [RS_IDX_W-1:0] freeIdx, issueIdx;
  logic                freeFound, issueFound, accept;

  assign full   = &busy_q;
  assign accept = in_valid && freeFound;

  always_comb begin
    readyVec = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      readyVec[i] = busy_q[i] && (ent_q[i].src1.tag == ZERO_ROB) && (ent_q[i].src2.tag == ZERO_ROB);
    end
  end

  rs_select #(.N(RS_SIZE), .W(RS_IDX_W)) freeSel (
    .reqVec_i(~busy_q),
    .idx_o   (freeIdx),
    .found_o (freeFound)
  );

  rs_select #(.N(RS_SIZE), .W(RS_IDX_W)) issueSel (
    .reqVec_i(readyVec),
    .idx_o   (issueIdx),
    .found_o (issueFound)
  );

  // Free slot comes from pre-edge busy bits, so a slot vacated by this cycle's issue is never reused now.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < RS_SIZE; i++) begin
      ent_d[i] = ent_q[i];
      if (busy_q[i]) begin
        ent_d[i].src1 = snoopOperand(ent_q[i].src1, alu_cdb_valid, alu_cdb_tag, alu_cdb_value,
                                     lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_value);
        ent_d[i].src2 = snoopOperand(ent_q[i].src2, alu_cdb_valid, alu_cdb_tag, alu_cdb_value,
                                     lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_value);
      end
    end
    if (issueFound) begin
      busy_d[issueIdx] = 1'b0;
    end
    if (accept) begin
      busy_d[freeIdx]         = 1'b1;
      ent_d[freeIdx].op       = in_op;
      ent_d[freeIdx].imm      = in_imm;
      ent_d[freeIdx].pc       = in_pc;
      ent_d[freeIdx].dest     = in_dest;
      ent_d[freeIdx].src1     = snoopOperand('{tag: in_tag1, value: in_operand1},
                                             alu_cdb_valid, alu_cdb_tag, alu_cdb_value,
                                             lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_value);
      ent_d[freeIdx].src2     = snoopOperand('{tag: in_tag2, value: in_operand2},
                                             alu_cdb_valid, alu_cdb_tag, alu_cdb_value,
                                             lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_value);
    end
  end

  // Entry payloads need no reset; busy alone decides whether an entry means anything.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ent_q[i] <= ent_d[i];
    end
    if (rst || flush) begin
      busy_q       <= '0;
      out_valid    <= 1'b0;
      out_op       <= NOP;
      out_operand1 <= '0;
      out_operand2 <= '0;
      out_imm      <= '0;
      out_pc       <= '0;
      out_dest     <= ZERO_ROB;
    end else begin
      busy_q    <= busy_d;
      out_valid <= issueFound;
      if (issueFound) begin
        out_op       <= ent_q[issueIdx].op;
        out_operand1 <= ent_q[issueIdx].src1.value;
        out_operand2 <= ent_q[issueIdx].src2.value;
        out_imm      <= ent_q[issueIdx].imm;
        out_pc       <= ent_q[issueIdx].pc;
        out_dest     <= ent_q[issueIdx].dest;
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Scoreboard bench for reservation_station: a behavioural model predicts each issue and the edge
// it lands on, and an independent monitor compares whatever the DUT presents on out_*.
module tb_reservation_station;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid;
  logic [5:0]  in_op;
  logic [31:0] in_imm, in_pc, in_operand1, in_operand2;
  logic [3:0]  in_tag1, in_tag2, in_dest;
  logic        full;
  logic        alu_cdb_valid, lsb_cdb_valid;
  logic [3:0]  alu_cdb_tag, lsb_cdb_tag;
  logic [31:0] alu_cdb_value, lsb_cdb_value;
  logic        out_valid;
  logic [5:0]  out_op;
  logic [31:0] out_operand1, out_operand2, out_imm, out_pc;
  logic [3:0]  out_dest;

  always #5 clk = ~clk;

  reservation_station dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_op(in_op),
    .in_imm(in_imm), .in_pc(in_pc), .in_operand1(in_operand1), .in_operand2(in_operand2),
    .in_tag1(in_tag1), .in_tag2(in_tag2), .in_dest(in_dest), .full(full),
    .alu_cdb_valid(alu_cdb_valid), .alu_cdb_tag(alu_cdb_tag), .alu_cdb_value(alu_cdb_value),
    .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_tag(lsb_cdb_tag), .lsb_cdb_value(lsb_cdb_value),
    .out_valid(out_valid), .out_op(out_op), .out_operand1(out_operand1),
    .out_operand2(out_operand2), .out_imm(out_imm), .out_pc(out_pc), .out_dest(out_dest)
  );

  typedef struct {
    int          edgeNum;
    logic [5:0]  op;
    logic [31:0] opnd1, opnd2, imm, pc;
    logic [3:0]  dest;
  } expect_t;

  expect_t sbQ[$];
  int edgeCount   = 0;
  int vectors     = 0;
  int miscompares = 0;

  // Reference model: an unordered pool of waiting instructions addressed by slot number.
  bit          mBusy [N];
  logic [5:0]  mOp   [N];
  logic [31:0] mImm  [N], mPc [N], mV1 [N], mV2 [N];
  logic [3:0]  mDest [N], mQ1 [N], mQ2 [N];

  always @(posedge clk) edgeCount++;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, actual, expected, edgeCount);
    end
  endtask

  function automatic int busyCount();
    int c = 0;
    for (int i = 0; i < N; i++) c += mBusy[i];
    return c;
  endfunction

  task automatic snoop(input logic [3:0] q, input logic [31:0] v, output logic [3:0] qo, output logic [31:0] vo);
    qo = q;
    vo = v;
    if (q != 4'd0 && alu_cdb_valid && alu_cdb_tag == q) begin
      qo = 4'd0; vo = alu_cdb_value;
    end else if (q != 4'd0 && lsb_cdb_valid && lsb_cdb_tag == q) begin
      qo = 4'd0; vo = lsb_cdb_value;
    end
  endtask

  // Predict the coming edge from the model's present contents and the inputs now on the pins.
  task automatic modelEdge();
    int      issued = -1;
    int      slot   = -1;
    bit      wasFull;
    expect_t e;
    if (rst || flush) begin
      for (int i = 0; i < N; i++) mBusy[i] = 1'b0;
      return;
    end
    wasFull = (busyCount() == N);
    for (int i = 0; i < N; i++)
      if (issued < 0 && mBusy[i] && mQ1[i] == 4'd0 && mQ2[i] == 4'd0) issued = i;
    if (issued >= 0) begin
      e.edgeNum = edgeCount + 1;
      e.op = mOp[issued]; e.opnd1 = mV1[issued]; e.opnd2 = mV2[issued];
      e.imm = mImm[issued]; e.pc = mPc[issued]; e.dest = mDest[issued];
      sbQ.push_back(e);
    end
    for (int i = 0; i < N; i++) begin
      if (mBusy[i]) begin
        snoop(mQ1[i], mV1[i], mQ1[i], mV1[i]);
        snoop(mQ2[i], mV2[i], mQ2[i], mV2[i]);
      end
    end
    if (in_valid && !wasFull) begin
      for (int i = 0; i < N; i++) if (slot < 0 && !mBusy[i]) slot = i;
      mBusy[slot] = 1'b1;
      mOp[slot] = in_op; mImm[slot] = in_imm; mPc[slot] = in_pc; mDest[slot] = in_dest;
      snoop(in_tag1, in_operand1, mQ1[slot], mV1[slot]);
      snoop(in_tag2, in_operand2, mQ2[slot], mV2[slot]);
    end
    if (issued >= 0) mBusy[issued] = 1'b0;
  endtask

  task automatic applyStimulus();
    modelEdge();
    @(posedge clk);
    #1;
    checkOutput("full", full, busyCount() == N);
  endtask

  task automatic idleInputs();
    rst = 0; flush = 0; in_valid = 0;
    in_op = 0; in_imm = 0; in_pc = 0; in_operand1 = 0; in_operand2 = 0;
    in_tag1 = 0; in_tag2 = 0; in_dest = 0;
    alu_cdb_valid = 0; alu_cdb_tag = 0; alu_cdb_value = 0;
    lsb_cdb_valid = 0; lsb_cdb_tag = 0; lsb_cdb_value = 0;
  endtask

  task automatic dispatch(input logic [5:0] op, input logic [31:0] o1, input logic [3:0] t1,
                          input logic [31:0] o2, input logic [3:0] t2, input logic [3:0] dest);
    in_valid = 1; in_op = op; in_operand1 = o1; in_tag1 = t1; in_operand2 = o2; in_tag2 = t2;
    in_dest = dest; in_imm = $urandom; in_pc = $urandom;
    applyStimulus();
    in_valid = 0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic aluBroadcast(input logic [3:0] tag, input logic [31:0] value);
    alu_cdb_valid = 1; alu_cdb_tag = tag; alu_cdb_value = value;
    applyStimulus();
    alu_cdb_valid = 0;
  endtask

  // Monitor: every issue must match the oldest prediction, including the edge it arrives on.
  always @(negedge clk) begin : monitor
    expect_t e;
    if (out_valid === 1'b1) begin
      if (sbQ.size() == 0) begin
        vectors++; miscompares++;
        $display("[TB] FAIL spurious_issue: out_valid=1 dest=%0d at edge %0d, expected no issue", out_dest, edgeCount);
      end else begin
        e = sbQ.pop_front();
        checkOutput("issue_edge", edgeCount, e.edgeNum);
        checkOutput("out_op", out_op, e.op);
        checkOutput("out_operand1", out_operand1, e.opnd1);
        checkOutput("out_operand2", out_operand2, e.opnd2);
        checkOutput("out_imm", out_imm, e.imm);
        checkOutput("out_pc", out_pc, e.pc);
        checkOutput("out_dest", out_dest, e.dest);
      end
    end else if (sbQ.size() > 0 && sbQ[0].edgeNum <= edgeCount) begin
      e = sbQ.pop_front();
      vectors++; miscompares++;
      $display("[TB] FAIL missed_issue: out_valid=0 at edge %0d, expected issue of dest %0d", edgeCount, e.dest);
    end
  end

  initial begin
    idleInputs();
    rst = 1;
    applyStimulus();
    applyStimulus();
    rst = 0;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_op", out_op, 0);
    checkOutput("reset_out_operand1", out_operand1, 0);
    checkOutput("reset_out_operand2", out_operand2, 0);
    checkOutput("reset_out_imm", out_imm, 0);
    checkOutput("reset_out_pc", out_pc, 0);
    checkOutput("reset_out_dest", out_dest, 0);

    dispatch(6'd1, 32'd5, 4'd0, 32'd7, 4'd0, 4'd3);
    idleCycles(2);

    dispatch(6'd2, 32'hdead, 4'd2, 32'd1, 4'd0, 4'd5);
    idleCycles(2);
    aluBroadcast(4'd2, 32'h1234);
    idleCycles(2);

    lsb_cdb_valid = 1; lsb_cdb_tag = 4'd6; lsb_cdb_value = 32'd9;
    dispatch(6'd3, 32'd4, 4'd0, 32'hbad, 4'd6, 4'd7);
    lsb_cdb_valid = 0;
    idleCycles(2);

    for (int i = 0; i < N; i++) dispatch(6'(i + 8), 32'hffff, 4'd1, 32'(i), 4'd0, 4'(i));
    dispatch(6'd63, 32'd0, 4'd0, 32'd0, 4'd0, 4'd9);
    aluBroadcast(4'd1, 32'h0badf00d);
    idleCycles(N + 2);

    for (int i = 0; i < 6; i++)
      dispatch(6'(i), 32'(i), (i == 2 || i == 5) ? 4'd4 : 4'd7, 32'(100 + i), 4'd0, 4'(i));
    lsb_cdb_valid = 1; lsb_cdb_tag = 4'd4; lsb_cdb_value = 32'h44;
    applyStimulus();
    lsb_cdb_valid = 0;
    idleCycles(3);
    aluBroadcast(4'd7, 32'h77);
    idleCycles(6);

    for (int i = 0; i < 4; i++) dispatch(6'd5, 32'd0, 4'(8 + i), 32'd0, 4'd0, 4'(i));
    flush = 1;
    applyStimulus();
    flush = 0;
    checkOutput("flush_out_valid", out_valid, 0);
    for (int i = 0; i < 2; i++) begin
      alu_cdb_valid = 1; alu_cdb_tag = 4'(8 + 2 * i); alu_cdb_value = 32'h5;
      lsb_cdb_valid = 1; lsb_cdb_tag = 4'(9 + 2 * i); lsb_cdb_value = 32'h6;
      applyStimulus();
    end
    idleInputs();
    idleCycles(3);

    for (int c = 0; c < 400; c++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_op       = 6'($urandom);
      in_imm      = $urandom;
      in_pc       = $urandom;
      in_operand1 = $urandom;
      in_operand2 = $urandom;
      in_tag1     = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15));
      in_tag2     = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15));
      in_dest     = 4'($urandom);
      alu_cdb_valid = ($urandom_range(0, 1) == 1);
      alu_cdb_tag   = 4'($urandom_range(0, 15));
      alu_cdb_value = $urandom;
      lsb_cdb_valid = ($urandom_range(0, 2) == 0);
      lsb_cdb_tag   = 4'($urandom_range(1, 15));
      lsb_cdb_value = $urandom;
      if (alu_cdb_valid && lsb_cdb_tag == alu_cdb_tag) lsb_cdb_valid = 0;
      flush = ($urandom_range(0, 59) == 0);
      applyStimulus();
    end
    idleInputs();

    for (int r = 0; r < 2; r++)
      for (int t = 1; t < 16; t++) aluBroadcast(4'(t), 32'(t * 3));
    idleCycles(N + 4);

    checkOutput("scoreboard_empty", sbQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
